// File: rtl/lwc_do_serial_fifo_if.sv
// Bundle of the core-side push channel, the do bus and the flush/occupancy
// signals around the do-channel serialising FIFO.
interface lwc_do_serial_fifo_if #(
    parameter int BUSW   = 32,
    parameter int CORE_W = 128,
    parameter int DEPTH  = 4
);
    logic [CORE_W-1:0]            in_data;
    logic                         in_valid;
    logic                         in_last;
    logic                         in_ready;
    logic [BUSW-1:0]              do_data;
    logic                         do_valid;
    logic                         do_last;
    logic                         do_ready;
    logic                         flush;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_data, in_valid, in_last, do_ready, flush,
        input  in_ready, do_data, do_valid, do_last, count
    );

    modport slave (
        input  in_data, in_valid, in_last, do_ready, flush,
        output in_ready, do_data, do_valid, do_last, count
    );
endinterface

// File: rtl/lwc_do_serial_fifo.sv
// Output buffer for the LWC do channel: queues CORE_W words with their last tag
// and serialises each onto the BUSW-bit do bus, most significant slice first.
module lwc_do_serial_fifo #(
    parameter int BUSW   = 32,
    parameter int CORE_W = 128,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    lwc_do_serial_fifo_if.slave   bus
);
    localparam int RATIO = CORE_W / BUSW;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    // bit CORE_W carries the last-of-message tag
    logic [CORE_W:0]   mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [BW-1:0]     beat;

    logic [CORE_W:0]   head;
    logic [BUSW-1:0]   slice;
    logic              valid;
    logic              last_beat;
    logic              push;
    logic              beat_acc;
    logic              pop;

    assign head      = mem[rd_ptr];
    assign valid     = (count_q != '0);
    assign last_beat = (beat == BW'(RATIO - 1));
    assign push      = bus.in_valid & bus.in_ready;
    assign beat_acc  = valid & bus.do_ready;
    assign pop       = beat_acc & last_beat;

    always_comb begin
        slice = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (beat == BW'(i)) begin
                slice = head[CORE_W-1-i*BUSW -: BUSW];
            end
        end
    end

    // in_ready depends on registered occupancy only, never on do_ready
    assign bus.in_ready = (count_q != CW'(DEPTH));
    assign bus.do_valid = valid;
    assign bus.do_data  = valid ? slice : '0;
    assign bus.do_last  = valid & head[CORE_W] & last_beat;
    assign bus.count    = count_q;

    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem[wr_ptr] <= {bus.in_last, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            beat    <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            beat    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (beat_acc) begin
                beat <= last_beat ? '0 : beat + BW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
